// File: rtl/bus_scan_reader.sv
// Scans a bank of tri-state registers sharing one bus, one at a time with
// break-before-make gaps, and hands the assembled word out over VALID/READY.
// Optional macro READBACK_COMPARE_EN: sample each register twice and flag mismatches on ERR.
module bus_scan_reader #(
    parameter int NUM_REGS = 4,
    parameter int NIB_W    = 4,
    parameter int SETTLE   = 1
) (
    input  logic                      CLK,
    input  logic                      CLR,
    input  logic                      START,
    input  logic [NIB_W-1:0]          BUS_IN,
    output logic [NUM_REGS-1:0]       OE,
    output logic [NUM_REGS*NIB_W-1:0] DATA_OUT,
    output logic                      VALID,
    input  logic                      READY,
    output logic                      BUSY,
    output logic                      ERR
);

`ifdef READBACK_COMPARE_EN
    localparam int WIN = SETTLE + 2;
`else
    localparam int WIN = SETTLE + 1;
`endif
    localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam int CNT_W = $clog2(WIN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [IDX_W-1:0]            idx;
    logic [CNT_W-1:0]            cnt;
    logic [NUM_REGS*NIB_W-1:0]   data;
    logic                        win_last;

    // Next-state and output decode; OE is released everywhere except the selected register in SEL.
    always_comb begin
        state_nxt = state;
        OE        = '1;
        win_last  = (cnt == LAST_CNT);
        case (state)
            IDLE: begin
                if (START) state_nxt = SEL;
            end
            SEL: begin
                OE[idx] = 1'b0;
                if (win_last) state_nxt = (idx == LAST_IDX) ? DONE : GAP;
            end
            GAP: begin
                state_nxt = SEL;
            end
            DONE: begin
                if (READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign VALID    = (state == DONE);
    assign BUSY     = (state != IDLE);
    assign DATA_OUT = data;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (START) begin
                        idx <= '0;
                        cnt <= '0;
                    end
                end
                SEL: begin
                    if (win_last) begin
                        cnt <= '0;
`ifndef READBACK_COMPARE_EN
                        data[idx*NIB_W +: NIB_W] <= BUS_IN;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`ifdef READBACK_COMPARE_EN
                    // First of the two samples is the one kept; the second only feeds the compare.
                    if (cnt == CNT_W'(WIN - 2)) data[idx*NIB_W +: NIB_W] <= BUS_IN;
`endif
                end
                GAP: begin
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef READBACK_COMPARE_EN
    logic err;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            err <= 1'b0;
        end else if (state == IDLE && START) begin
            err <= 1'b0;
        end else if (state == SEL && win_last && BUS_IN != data[idx*NIB_W +: NIB_W]) begin
            err <= 1'b1;
        end
    end

    assign ERR = err;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_bus_scan_reader.sv
// Scoreboard bench for bus_scan_reader: a behavioural register bank drives the
// shared bus with one cycle of OE-to-drive latency, expected words are queued at START.
module tb_bus_scan_reader;

    localparam int NUM_REGS = 4;
    localparam int NIB_W    = 4;
    localparam int SETTLE   = 1;
`ifdef READBACK_COMPARE_EN
    localparam int WIN = SETTLE + 2;
`else
    localparam int WIN = SETTLE + 1;
`endif
    localparam int PER = WIN + 1;
    localparam int LAT = WIN * NUM_REGS + (NUM_REGS - 1);

    logic                      CLK = 1'b0;
    logic                      CLR;
    logic                      START;
    logic [NIB_W-1:0]          BUS_IN;
    logic [NUM_REGS-1:0]       OE;
    logic [NUM_REGS*NIB_W-1:0] DATA_OUT;
    logic                      VALID;
    logic                      READY;
    logic                      BUSY;
    logic                      ERR;

    logic [NIB_W-1:0]    reg_val [NUM_REGS];
    logic [NUM_REGS-1:0] drv = '0;
    logic [NUM_REGS-1:0] prev_z = '0;
    int                  viol = 0;
    int                  tests = 0;
    int                  fails = 0;
    int                  mod_at = -1;
    logic [63:0]         sb [$];

    bus_scan_reader #(.NUM_REGS(NUM_REGS), .NIB_W(NIB_W), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .BUS_IN(BUS_IN), .OE(OE),
        .DATA_OUT(DATA_OUT), .VALID(VALID), .READY(READY), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // Register bank: each register samples its OE on the rising edge and drives one cycle later.
    always @(posedge CLK) drv <= ~OE;

    always_comb begin
        BUS_IN = '1;
        for (int i = 0; i < NUM_REGS; i++)
            if (drv[i]) BUS_IN = reg_val[i];
    end

    // Contention monitor: one enabled register at most, and never a new one right after another.
    always @(negedge CLK) begin
        if ($countones(~OE) > 1) viol++;
        if (prev_z != '0 && ~OE != '0 && ~OE != prev_z) viol++;
        if ($countones(drv) > 1) viol++;
        prev_z = ~OE;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [NUM_REGS-1:0] expOe(input int n);
        logic [NUM_REGS-1:0] one = 1;
        if ((n % PER) < WIN) return ~(one << (n / PER));
        return '1;
    endfunction

    function automatic logic [63:0] curWord();
        logic [63:0] w = '0;
        for (int i = 0; i < NUM_REGS; i++) w[i*NIB_W +: NIB_W] = reg_val[i];
        return w;
    endfunction

    // Pulses START from IDLE and records the word the scan should return.
    task automatic applyStimulus(input logic [15:0] vals);
        for (int i = 0; i < NUM_REGS; i++) reg_val[i] = vals[i*NIB_W +: NIB_W];
        sb.push_back(curWord());
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic runScan(input bit chk_oe, output int n);
        n = 0;
        while (!VALID && n < 200) begin
            if (chk_oe && n < LAT) checkOutput("oe_seq", OE, expOe(n));
            if (n == mod_at) reg_val[1] = 4'h6;
            tick();
            n++;
        end
    endtask

    task automatic consume(input int hold);
        logic [63:0] exp;
        for (int i = 0; i < hold; i++) tick();
        READY = 1'b1;
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
        checkOutput("data", DATA_OUT, exp);
        tick();
        READY = 1'b0;
        checkOutput("valid_drop", VALID, 1'b0);
    endtask

    initial begin
        int n;
        int vcount;
        CLR   = 1'b1;
        START = 1'b0;
        READY = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) reg_val[i] = '0;
        tick();
        tick();
        CLR = 1'b0;
        checkOutput("rst_oe", OE, 4'hF);
        checkOutput("rst_valid", VALID, 1'b0);
        checkOutput("rst_busy", BUSY, 1'b0);
        checkOutput("rst_data", DATA_OUT, 16'h0);
        checkOutput("rst_err", ERR, 1'b0);

        // Reset in the middle of register 2's select window.
        applyStimulus(16'h3C5A);
        for (int i = 0; i < 2 * PER; i++) tick();
        checkOutput("mid_oe", OE, 4'b1011);
        CLR = 1'b1;
        tick();
        tick();
        CLR = 1'b0;
        void'(sb.pop_back());
        checkOutput("clr_oe", OE, 4'hF);
        checkOutput("clr_valid", VALID, 1'b0);
        checkOutput("clr_busy", BUSY, 1'b0);
        checkOutput("clr_data", DATA_OUT, 16'h0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (VALID) vcount++;
            tick();
        end
        checkOutput("no_valid_after_clr", vcount, 0);

        // Basic scan with the OE sequence, then back-pressure.
        applyStimulus(16'h3C5A);
`ifdef READBACK_COMPARE_EN
        mod_at = PER + WIN - 1;
`endif
        runScan(1'b1, n);
        mod_at = -1;
        checkOutput("latency", n, LAT);
`ifdef READBACK_COMPARE_EN
        checkOutput("err_set", ERR, 1'b1);
        checkOutput("nib1_first", DATA_OUT[7:4], 4'h5);
`else
        checkOutput("err_zero", ERR, 1'b0);
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_valid", VALID, 1'b1);
            checkOutput("hold_data", DATA_OUT, 16'h3C5A);
        end
        consume(0);
        checkOutput("idle_busy", BUSY, 1'b0);
        checkOutput("kept_data", DATA_OUT, 16'h3C5A);

        // START while busy is ignored; START on the handshake edge is ignored too.
        applyStimulus(16'h4321);
`ifdef READBACK_COMPARE_EN
        checkOutput("err_cleared", ERR, 1'b0);
`endif
        tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        runScan(1'b0, n);
        checkOutput("latency_sel_start", n + 2, LAT);
        START = 1'b1;
        tick();
        START = 1'b0;
        checkOutput("done_start_valid", VALID, 1'b1);
        START = 1'b1;
        READY = 1'b1;
        checkOutput("data", DATA_OUT, sb.pop_front());
        tick();
        START = 1'b0;
        READY = 1'b0;
        checkOutput("hs_start_busy", BUSY, 1'b0);
        checkOutput("hs_start_valid", VALID, 1'b0);
        applyStimulus(16'h9E07);
        checkOutput("restart_busy", BUSY, 1'b1);
        runScan(1'b0, n);
        checkOutput("latency_restart", n, LAT);
        consume(1);

        // Random scans with random back-pressure and random clears.
        for (int k = 0; k < 50; k++) begin
            applyStimulus(16'($urandom));
            if ($urandom_range(3) == 0) begin
                for (int i = 0; i < $urandom_range(LAT + 3); i++) tick();
                CLR = 1'b1;
                tick();
                CLR = 1'b0;
                void'(sb.pop_back());
                checkOutput("rnd_clr_busy", BUSY, 1'b0);
            end else begin
                runScan(1'b0, n);
                checkOutput("rnd_latency", n, LAT);
                consume($urandom_range(4));
            end
            for (int i = 0; i < $urandom_range(3); i++) tick();
        end

        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("oe_exclusive", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
